// File: rtl/fpu_arbiter.sv
// fpu_arbiter: shares one floating-point adder between two requesters.
// Requests are granted round-robin. The winner's operands are registered onto
// the adder for LAT cycles. The result is then captured and held on a response
// handshake for the owning port until that port consumes it.
//
// Ports:
//   clk, reset_n                    clock, asynchronous active-low reset
//   reqN_valid/ready/a/b/single     request handshake and operands for port N (0, 1)
//   rspN_valid/ready                response handshake for port N
//   rsp_result                      captured result, shared by both response ports
//   fpu_a, fpu_b, fpu_single        operands and precision select driven to the adder
//   fpu_result                      combinational adder result
//   busy                            an operation is in flight (not idle)
//   op_count                        completed operations, wraps at 16 bits
module fpu_arbiter #(
  parameter int unsigned LAT = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic        req0_single,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  input  logic        req1_single,
  output logic        rsp0_valid,
  input  logic        rsp0_ready,
  output logic        rsp1_valid,
  input  logic        rsp1_ready,
  output logic [31:0] rsp_result,
  output logic [31:0] fpu_a,
  output logic [31:0] fpu_b,
  output logic        fpu_single,
  input  logic [31:0] fpu_result,
  output logic        busy,
  output logic [15:0] op_count
);

  localparam logic [3:0] CntInit = 4'(LAT - 1);

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e      state_q, state_d;
  logic        last_grant_q, owner_q, single_q;
  logic [3:0]  cnt_q;
  logic [31:0] a_q, b_q, result_q;
  logic [15:0] op_count_q;

  logic grant0, grant1, accept0, accept1, accept;
  logic rsp_ready_own, rsp_fire, capture;

  // Arbitration: a lone requester always wins; on contention the port that
  // was not granted last time wins.
  always_comb begin
    grant0        = req0_valid & (~req1_valid | last_grant_q);
    grant1        = req1_valid & (~req0_valid | ~last_grant_q);
    accept0       = (state_q == StIdle) & grant0;
    accept1       = (state_q == StIdle) & grant1;
    accept        = accept0 | accept1;
    rsp_ready_own = owner_q ? rsp1_ready : rsp0_ready;
    rsp_fire      = (state_q == StResp) & rsp_ready_own;
    capture       = (state_q == StWait) & (cnt_q == 4'd0);
  end

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (accept) state_d = StWait;
      StWait:  if (cnt_q == 4'd0) state_d = StResp;
      StResp:  if (rsp_ready_own) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs. Readys are gated by reset_n so no handshake is offered while the
  // block is held in reset; internal accept needs no gating since every flop
  // is held in reset anyway.
  always_comb begin
    req0_ready = reset_n & accept0;
    req1_ready = reset_n & accept1;
    busy       = (state_q != StIdle);
    rsp0_valid = (state_q == StResp) & ~owner_q;
    rsp1_valid = (state_q == StResp) & owner_q;
    rsp_result = result_q;
    fpu_a      = a_q;
    fpu_b      = b_q;
    fpu_single = single_q;
    op_count   = op_count_q;
  end

  // Operand, owner and latency counter registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_q          <= 32'h0;
      b_q          <= 32'h0;
      single_q     <= 1'b0;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
      cnt_q        <= 4'd0;
    end else if (accept) begin
      a_q          <= accept1 ? req1_a : req0_a;
      b_q          <= accept1 ? req1_b : req0_b;
      single_q     <= accept1 ? req1_single : req0_single;
      owner_q      <= accept1;
      last_grant_q <= accept1;
      cnt_q        <= CntInit;
    end else if ((state_q == StWait) && (cnt_q != 4'd0)) begin
      cnt_q <= cnt_q - 4'd1;
    end
  end

  // Result capture; half-precision results carry no upper-half bits.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      result_q <= 32'h0;
    end else if (capture) begin
      result_q <= single_q ? fpu_result : {16'h0, fpu_result[15:0]};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      op_count_q <= 16'h0;
    end else if (rsp_fire) begin
      op_count_q <= op_count_q + 16'd1;
    end
  end

endmodule

// File: doc/fpu_arbiter.md
# fpu_arbiter

Sequencing and sharing controller for the floating-point adder. Two requesters (port 0: main datapath execute stage, port 1: secondary/coprocessor path) issue add operations over valid/ready handshakes. The block grants one at a time round-robin, registers operands into the shared adder, waits a fixed number of cycles, and captures the result. It then returns the result to the owning requester over a response handshake with backpressure.

## Interface
- LAT, 1, cycles operands are held on the adder before the result is captured; legal 1..15
- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous, active-low reset
- req0_valid / req1_valid  input  1  request pending on port N
- req0_ready / req1_ready  output  1  port N request accepted this cycle (valid && ready)
- req0_a, req0_b / req1_a, req1_b  input  32  operands
- req0_single / req1_single  input  1  1 = single precision, 0 = half (operands in [15:0])
- rsp0_valid / rsp1_valid  output  1  result available for port N
- rsp0_ready / rsp1_ready  input  1  port N consumes result
- rsp_result  output  32  result shared by both response ports; meaningful only while a rspN_valid is high
- fpu_a, fpu_b  output  32  operands driven to the adder
- fpu_single  output  1  precision select to the adder
- fpu_result  input  32  combinational adder result
- busy  output  1  state != IDLE
- op_count  output  16  completed operations; wraps 0xFFFF -> 0x0000

## Operation
- FSM states: IDLE, WAIT, RESP. Reset state: IDLE.
- IDLE:
  - Arbitrate between valid requests and assert reqN_ready combinationally only to the winner.
  - Never assert both readys. Never assert a ready without its valid.
  - On handshake, register a, b, single and owner (0/1), load cnt = LAT-1, and go to WAIT.
- Round-robin: last_grant register, reset 1, so port 0 wins the first contention.
  - If both ports are valid, the port != last_grant wins.
  - If one port is valid, it wins regardless of last_grant.
  - last_grant updates only on handshake.
- WAIT:
  - fpu_a/fpu_b/fpu_single are driven from the operand registers and are stable for the whole op.
  - When cnt == 0, capture fpu_result into the result register and go to RESP. Otherwise decrement cnt.
  - In half mode (single = 0), captured bits [31:16] are forced to 0.
- RESP:
  - rsp<owner>_valid is high; the other response valid stays low.
  - rsp_result holds the captured value.
  - On rsp<owner>_ready, increment op_count and go to IDLE. Stay in RESP indefinitely otherwise.
- No new request is accepted outside IDLE; both reqN_ready are low in WAIT and RESP.
- rspN_ready arriving while rspN_valid is low is ignored.
- Reset mid-operation: return to IDLE immediately and discard the in-flight op; it produces no response and no op_count increment.
- Reset values:
  - All registered outputs are 0: fpu_a, fpu_b, fpu_single, rsp_result, op_count, both rspN_valid, busy.
  - Both reqN_ready are low while reset_n is low.
  - Internal state: last_grant = 1, cnt = 0.

## Timing
- Request accepted at edge k: WAIT spans edges k+1 .. k+LAT.
- Result captured at edge k+LAT; rspN_valid is high from edge k+LAT.
- Response consumed at edge m: IDLE from m; the next request can be accepted at edge m+1 (ready asserted combinationally in the cycle after m).
- Back-to-back throughput with ready always high: one op per LAT+2 cycles.
- rsp_result and rspN_valid are registered outputs; reqN_ready is combinational from state, valids and last_grant.
- op_count increments on the response handshake edge.

## Test plan
- Reset, then port 0 single request, a=0x3F800000, b=0x3F800000, LAT=1:
  - req0_ready high in the same cycle.
  - rsp0_valid high 1 edge later with rsp_result=0x40000000.
  - rsp1_valid stays low.
  - op_count=1 after rsp0_ready.
- Both ports valid continuously, port0 a=b=0x3F800000, port1 a=b=0x40000000, rsp readys high:
  - Grants alternate 0,1,0,1.
  - Responses alternate 0x40000000 / 0x40800000.
  - One op per LAT+2 cycles.
- LAT=4, single request, rsp0_ready held low 10 cycles:
  - rsp0_valid rises exactly 4 edges after acceptance and stays high with a stable value.
  - Both reqN_ready stay low the whole time.
  - Op completes on the ready edge.
- Half-precision request (single=0), req1_a=0xFFFF1234, req1_b=0xABCD5678:
  - fpu_single=0 during WAIT.
  - rsp_result[31:16]=0x0000.
  - rsp_result[15:0] equals the adder's half output for 0x1234+0x5678.
- Assert reset_n low during WAIT:
  - All outputs go to reset values asynchronously.
  - No response after release.
  - op_count=0.
  - The next contention is granted to port 0.
- Preload op_count to 0xFFFF by running 65535 ops (or force in sim), then one more op -> op_count=0x0000.
